// File: rtl/lzrw1_compressor.sv
// LZRW1 block compressor: buffers a block of up to 2^ADDR_W bytes, then emits
// literal/copy items found through a single-probe hash table of earlier positions.
module lzrw1_compressor #(
  parameter int ADDR_W  = 12,
  parameter int HASH_W  = 8,
  parameter int MAX_LEN = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] data_out,
  output logic        control_word_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        compressor_busy
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRIES = 1 << HASH_W;
  localparam int CW      = ADDR_W + 1;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {LOAD, HASH, COMPARE, EMIT} state_t;

  state_t state, state_d;

  logic [7:0]         history  [DEPTH];
  logic [ADDR_W-1:0]  hash_pos [ENTRIES];
  logic [ENTRIES-1:0] hash_valid;

  logic [CW-1:0]     byte_cnt, pos, remaining, emit_end, item_end;
  logic [ADDR_W-1:0] cand, pa;
  logic [LEN_W-1:0]  len, item_len, emit_len;
  logic [7:0]        b0, b1, b2, h8, cmp_a, cmp_b;
  logic [HASH_W-1:0] h;
  logic              accept, load_done, xfer, can_hash, cmp_stop, emit_go, emit_copy;

  assign pa        = pos[ADDR_W-1:0];
  assign remaining = byte_cnt - pos;
  assign can_hash  = remaining >= CW'(3);

  assign b0 = history[pa];
  assign b1 = history[pa + ADDR_W'(1)];
  assign b2 = history[pa + ADDR_W'(2)];
  assign h8 = b0 ^ {b1[5:0], b1[7:6]} ^ {b2[3:0], b2[7:4]};
  assign h  = h8[HASH_W-1:0];

  // Candidate and current streams advance together, so overlapping copies work naturally.
  assign cmp_a    = history[cand + ADDR_W'(len)];
  assign cmp_b    = history[pa + ADDR_W'(len)];
  assign cmp_stop = (len == LEN_W'(MAX_LEN)) || (pos + CW'(len) == byte_cnt) || (cmp_a != cmp_b);

  assign in_ready  = (state == LOAD);
  assign accept    = in_ready & in_valid;
  assign load_done = accept & (in_last | (byte_cnt == CW'(DEPTH - 1)));
  assign xfer      = out_valid & out_ready;
  assign emit_end  = pos + CW'(emit_len);
  assign item_end  = pos + CW'(item_len);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state;
    emit_go   = 1'b0;
    emit_copy = 1'b0;
    emit_len  = LEN_W'(1);
    unique case (state)
      LOAD:    if (load_done) state_d = HASH;
      HASH: begin
        if (can_hash && hash_valid[h]) begin
          state_d = COMPARE;
        end else begin
          emit_go = 1'b1;
          state_d = EMIT;
        end
      end
      COMPARE: begin
        if (cmp_stop) begin
          emit_go = 1'b1;
          state_d = EMIT;
          if (len >= LEN_W'(3)) begin
            emit_copy = 1'b1;
            emit_len  = len;
          end
        end
      end
      EMIT:    if (out_ready) state_d = (item_end < byte_cnt) ? HASH : LOAD;
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= LOAD;
      byte_cnt         <= '0;
      pos              <= '0;
      cand             <= '0;
      len              <= '0;
      item_len         <= '0;
      hash_valid       <= '0;
      out_valid        <= 1'b0;
      out_last         <= 1'b0;
      compressor_busy  <= 1'b0;
      data_out         <= 16'h0000;
      control_word_out <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) byte_cnt <= byte_cnt + CW'(1);
      if (load_done) begin
        pos             <= '0;
        hash_valid      <= '0;
        compressor_busy <= 1'b1;
      end
      // Table is probed and refreshed only at item start positions.
      if (state == HASH && can_hash) begin
        hash_valid[h] <= 1'b1;
        cand          <= hash_pos[h];
        len           <= '0;
      end
      if (state == COMPARE && !cmp_stop) len <= len + LEN_W'(1);
      if (emit_go) begin
        out_valid        <= 1'b1;
        item_len         <= emit_len;
        out_last         <= (emit_end == byte_cnt);
        control_word_out <= emit_copy;
        data_out         <= emit_copy ? {4'(len - LEN_W'(3)), 12'(pos - CW'(cand))}
                                      : {8'h00, history[pa]};
      end
      if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        pos       <= item_end;
        if (item_end == byte_cnt) begin
          byte_cnt        <= '0;
          pos             <= '0;
          compressor_busy <= 1'b0;
        end
      end
    end
  end

  // NOTE: history and table payloads are not reset; the valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (accept) history[byte_cnt[ADDR_W-1:0]] <= in_byte;
    if (state == HASH && can_hash) hash_pos[h] <= pa;
  end

endmodule
